// File: rtl/mxu_pkg.sv
// Shared types and default dimensions for the weight-stationary systolic matrix unit.
package mxu_pkg;

    localparam int unsigned DefaultRows  = 4;
    localparam int unsigned DefaultCols  = 4;
    localparam int unsigned DefaultDataW = 8;
    localparam int unsigned DefaultAccW  = 32;
    localparam int unsigned DefaultOutW  = 16;

    typedef enum logic [1:0] {
        StIdle,
        StLoadW,
        StCompute,
        StDrain
    } mxu_state_e;

endpackage

// File: rtl/mxu_pe.sv
// Processing element: stationary weight, eastward activation register, MAC into a southward
// partial-sum register.
module mxu_pe #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              signed_mode,
    input  logic              w_load,
    input  logic [DATA_W-1:0] w_in,
    input  logic [DATA_W-1:0] a_in,
    input  logic [ACC_W-1:0]  psum_in,
    output logic [DATA_W-1:0] a_out,
    output logic [ACC_W-1:0]  psum_out
);

    logic [DATA_W-1:0]   w_q;
    logic [DATA_W-1:0]   a_q;
    logic [ACC_W-1:0]    psum_q;
    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] w_ext;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    prod_ext;

    // Operands are extended to the product width so one unsigned multiplier serves both modes;
    // the low 2*DATA_W bits of a two's-complement product are mode independent.
    always_comb begin
        a_ext    = signed_mode ? {{DATA_W{a_in[DATA_W-1]}}, a_in} : {{DATA_W{1'b0}}, a_in};
        w_ext    = signed_mode ? {{DATA_W{w_q[DATA_W-1]}}, w_q} : {{DATA_W{1'b0}}, w_q};
        prod     = a_ext * w_ext;
        prod_ext = signed_mode ? ACC_W'($signed(prod)) : ACC_W'(prod);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_q    <= '0;
            a_q    <= '0;
            psum_q <= '0;
        end else begin
            if (w_load) begin
                w_q <= w_in;
            end
            if (en) begin
                a_q    <= a_in;
                psum_q <= psum_in + prod_ext;
            end
        end
    end

    assign a_out    = a_q;
    assign psum_out = psum_q;

endmodule

// File: rtl/systolic_mxu.sv
// Weight-stationary ROWS x COLS systolic matrix unit with skewed inputs and deskewed outputs.
// Define MXU_SATURATE_EN to clamp each column sum to the OUT_W range instead of wrapping.
module systolic_mxu
    import mxu_pkg::*;
#(
    parameter int unsigned ROWS   = DefaultRows,
    parameter int unsigned COLS   = DefaultCols,
    parameter int unsigned DATA_W = DefaultDataW,
    parameter int unsigned ACC_W  = DefaultAccW,
    parameter int unsigned OUT_W  = DefaultOutW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   signed_mode,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [COLS*DATA_W-1:0] w_data,
    input  logic                   a_valid,
    output logic                   a_ready,
    input  logic [ROWS*DATA_W-1:0] a_data,
    input  logic                   a_last,
    output logic                   r_valid,
    input  logic                   r_ready,
    output logic [COLS*OUT_W-1:0]  r_data,
    output logic                   busy
);

    localparam int unsigned Lat  = ROWS + COLS;
    localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;

    mxu_state_e            state_q, state_d;
    logic [RowW-1:0]       row_q, row_d;
    logic                  loaded_q, loaded_d;
    logic                  signed_q, signed_d;
    logic [Lat:0]          tok_q;
    logic [ROWS*DATA_W-1:0] a_in_q;
    logic [COLS*OUT_W-1:0] r_data_q;
    logic [COLS*OUT_W-1:0] res_data;
    logic                  stall, en, w_fire, a_fire, w_last_beat, drain_done;

    logic [DATA_W-1:0] skew_out [ROWS];
    logic [DATA_W-1:0] a_fwd    [ROWS][COLS];
    logic [ACC_W-1:0]  psum     [ROWS][COLS];
    logic [ACC_W-1:0]  col_sum  [COLS];

    assign stall   = tok_q[Lat] && !r_ready;
    assign en      = !stall;
    assign w_ready = (state_q == StIdle) || (state_q == StLoadW);
    // A pending weight beat wins in IDLE, so the activation is not handshaken alongside it.
    assign a_ready = (((state_q == StIdle) && !w_valid) || (state_q == StCompute)) &&
                     loaded_q && en;
    assign w_fire      = w_valid && w_ready;
    assign a_fire      = a_valid && a_ready;
    assign w_last_beat = (row_q == RowW'(ROWS - 1));
    assign drain_done  = tok_q[Lat] && r_ready && !(|tok_q[Lat-1:0]);
    assign busy        = (state_q != StIdle);
    assign r_valid     = tok_q[Lat];
    assign r_data      = r_data_q;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        loaded_d = loaded_q;
        signed_d = signed_q;
        if (w_fire) begin
            row_d = w_last_beat ? '0 : row_q + RowW'(1);
            if (row_q == '0) begin
                signed_d = signed_mode;
            end
            if (w_last_beat) begin
                loaded_d = 1'b1;
            end
        end
        case (state_q)
            StIdle: begin
                if (w_fire) begin
                    state_d = w_last_beat ? StIdle : StLoadW;
                end else if (a_fire) begin
                    state_d = a_last ? StDrain : StCompute;
                end
            end
            StLoadW: begin
                if (w_fire && w_last_beat) begin
                    state_d = StIdle;
                end
            end
            StCompute: begin
                if (a_fire && a_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (drain_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            row_q    <= '0;
            loaded_q <= 1'b0;
            signed_q <= 1'b0;
            tok_q    <= '0;
            a_in_q   <= '0;
            r_data_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            loaded_q <= loaded_d;
            signed_q <= signed_d;
            if (en) begin
                tok_q    <= {tok_q[Lat-1:0], a_fire};
                a_in_q   <= a_fire ? a_data : '0;
                r_data_q <= res_data;
            end
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign skew_out[i] = a_in_q[DATA_W-1:0];
        end else begin : g_delay
            logic [DATA_W-1:0] sr_q [i];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < i; k++) begin
                        sr_q[k] <= '0;
                    end
                end else if (en) begin
                    sr_q[0] <= a_in_q[i*DATA_W +: DATA_W];
                    for (int k = 1; k < i; k++) begin
                        sr_q[k] <= sr_q[k-1];
                    end
                end
            end
            assign skew_out[i] = sr_q[i-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic [DATA_W-1:0] a_src;
            logic [ACC_W-1:0]  ps_src;
            if (j == 0) begin : g_a_edge
                assign a_src = skew_out[i];
            end else begin : g_a_inner
                assign a_src = a_fwd[i][j-1];
            end
            if (i == 0) begin : g_p_edge
                assign ps_src = '0;
            end else begin : g_p_inner
                assign ps_src = psum[i-1][j];
            end
            mxu_pe #(
                .DATA_W(DATA_W),
                .ACC_W (ACC_W)
            ) u_pe (
                .clk        (clk),
                .reset      (reset),
                .en         (en),
                .signed_mode(signed_q),
                .w_load     (w_fire && (row_q == RowW'(i))),
                .w_in       (w_data[j*DATA_W +: DATA_W]),
                .a_in       (a_src),
                .psum_in    (ps_src),
                .a_out      (a_fwd[i][j]),
                .psum_out   (psum[i][j])
            );
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_deskew
        localparam int unsigned Depth = COLS - 1 - j;
        logic [OUT_W-1:0] res;
        if (Depth == 0) begin : g_direct
            assign col_sum[j] = psum[ROWS-1][j];
        end else begin : g_delay
            logic [ACC_W-1:0] dq [Depth];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < Depth; k++) begin
                        dq[k] <= '0;
                    end
                end else if (en) begin
                    dq[0] <= psum[ROWS-1][j];
                    for (int k = 1; k < Depth; k++) begin
                        dq[k] <= dq[k-1];
                    end
                end
            end
            assign col_sum[j] = dq[Depth-1];
        end
`ifdef MXU_SATURATE_EN
        logic [ACC_W-1:0] hi_u;
        logic [ACC_W-1:0] hi_s;
        // The sum fits when the bits above the result width are pure extension bits.
        always_comb begin
            hi_u = col_sum[j] >> OUT_W;
            hi_s = $signed(col_sum[j]) >>> (OUT_W - 1);
            if (signed_q) begin
                if ((hi_s == '0) || (hi_s == '1)) begin
                    res = col_sum[j][OUT_W-1:0];
                end else if (col_sum[j][ACC_W-1]) begin
                    res = {1'b1, {(OUT_W-1){1'b0}}};
                end else begin
                    res = {1'b0, {(OUT_W-1){1'b1}}};
                end
            end else begin
                res = (hi_u == '0) ? col_sum[j][OUT_W-1:0] : '1;
            end
        end
`else
        assign res = col_sum[j][OUT_W-1:0];
`endif
        assign res_data[j*OUT_W +: OUT_W] = res;
    end

endmodule

// File: tb/tb_systolic_mxu.sv
// Scoreboard bench for systolic_mxu: directed weight/activation vectors, expected results queued
// at acceptance and checked by an independent output monitor.
module tb_systolic_mxu;

    localparam int ROWS = 4, COLS = 4, DATA_W = 8, ACC_W = 32, OUT_W = 16;

`ifdef MXU_SATURATE_EN
    localparam int ExpU = 65535;
    localparam int ExpS = 32767;
`else
    localparam int ExpU = 63492;
    localparam int ExpS = 0;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   signed_mode;
    logic                   w_valid;
    logic                   w_ready;
    logic [COLS*DATA_W-1:0] w_data;
    logic                   a_valid;
    logic                   a_ready;
    logic [ROWS*DATA_W-1:0] a_data;
    logic                   a_last;
    logic                   r_valid;
    logic                   r_ready;
    logic [COLS*OUT_W-1:0]  r_data;
    logic                   busy;

    logic [63:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [63:0] held;

    systolic_mxu #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .signed_mode(signed_mode),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_data     (a_data),
        .a_last     (a_last),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_data     (r_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pk(input int c0, input int c1, input int c2, input int c3);
        return {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    endfunction

    function automatic logic [31:0] v4(input int b0, input int b1, input int b2, input int b3);
        return {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Output monitor: every handshaken result must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && r_valid && r_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got %0h want none", r_data);
            end else begin
                check("result", r_data, exp_q.pop_front());
            end
        end
    end

    task automatic load_w(input logic sm, input logic [127:0] w, input int first);
        for (int k = first; k < ROWS; k++) begin
            int n;
            signed_mode = sm;
            w_valid     = 1'b1;
            w_data      = w[k*32 +: 32];
            n = 0;
            @(negedge clk);
            while (!w_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            if (!w_ready) check("w_handshake_timeout", 64'(w_ready), 64'd1);
            @(posedge clk);
            #1;
        end
        w_valid = 1'b0;
    endtask

    task automatic send_a(input logic [31:0] v, input logic last, input logic [63:0] exp);
        int n;
        a_valid = 1'b1;
        a_data  = v;
        a_last  = last;
        n = 0;
        @(negedge clk);
        while (!a_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!a_ready) check("a_handshake_timeout", 64'(a_ready), 64'd1);
        else exp_q.push_back(exp);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        a_valid = 1'b0;
        a_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached with %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] w_id, w_ff, w_80, w_mix, w_2id;
        int n;
        w_id  = {v4(0, 0, 0, 1), v4(0, 0, 1, 0), v4(0, 1, 0, 0), v4(1, 0, 0, 0)};
        w_ff  = {4{v4(255, 255, 255, 255)}};
        w_80  = {4{v4(128, 128, 128, 128)}};
        w_mix = {v4(1, 1, 1, 1), v4(0, 0, 1, 1), v4(0, 1, 0, 1), v4(1, 0, 0, 1)};
        w_2id = {v4(0, 0, 0, 2), v4(0, 0, 2, 0), v4(0, 2, 0, 0), v4(2, 0, 0, 0)};

        reset = 1'b1; signed_mode = 1'b0; w_valid = 1'b0; w_data = '0;
        a_valid = 1'b0; a_data = '0; a_last = 1'b0; r_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_r_valid", 64'(r_valid), 64'd0);
        check("reset_r_data", r_data, 64'd0);
        check("reset_a_ready", 64'(a_ready), 64'd0);
        check("reset_w_ready", 64'(w_ready), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        // Identity weights, latency from acceptance to r_valid.
        load_w(1'b0, w_id, 0);
        @(negedge clk);
        check("a_ready_after_load", 64'(a_ready), 64'd1);
        @(posedge clk);
        #1;
        send_a(v4(1, 2, 3, 4), 1'b1, pk(1, 2, 3, 4));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!r_valid && n < 40);
        check("latency", 64'(cyc - acc_cyc), 64'd8);
        wait_idle();

        // Unsigned and signed extremes.
        load_w(1'b0, w_ff, 0);
        send_a(v4(255, 255, 255, 255), 1'b1, pk(ExpU, ExpU, ExpU, ExpU));
        wait_idle();
        load_w(1'b1, w_80, 0);
        send_a(v4(128, 128, 128, 128), 1'b1, pk(ExpS, ExpS, ExpS, ExpS));
        wait_idle();

        // Stream with a bubble; hold off the first result for five cycles.
        load_w(1'b0, w_mix, 0);
        r_ready = 1'b0;
        send_a(v4(1, 2, 3, 4), 1'b0, pk(5, 6, 7, 10));
        @(posedge clk);
        #1;
        send_a(v4(10, 20, 30, 40), 1'b0, pk(50, 60, 70, 100));
        send_a(v4(0, 1, 0, 2), 1'b0, pk(2, 3, 2, 3));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!r_valid && n < 40);
        held = r_data;
        check("stall_first_valid", 64'(r_valid), 64'd1);
        check("stall_a_ready", 64'(a_ready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_hold_data", r_data, held);
            check("stall_hold_valid", 64'(r_valid), 64'd1);
            check("stall_a_ready", 64'(a_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        r_ready = 1'b1;
        send_a(v4(2, 2, 2, 2), 1'b1, pk(4, 4, 4, 8));
        wait_idle();

        // Reset with two vectors in flight.
        send_a(v4(1, 2, 3, 4), 1'b0, pk(5, 6, 7, 10));
        send_a(v4(1, 1, 1, 1), 1'b0, pk(2, 2, 2, 4));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        check("midreset_r_valid", 64'(r_valid), 64'd0);
        check("midreset_w_ready", 64'(w_ready), 64'd1);
        check("midreset_a_ready", 64'(a_ready), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("no_stale_result", 64'(r_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // a_last on the second vector with a weight reload held pending through DRAIN.
        load_w(1'b0, w_id, 0);
        send_a(v4(1, 2, 3, 4), 1'b0, pk(1, 2, 3, 4));
        send_a(v4(4, 3, 2, 1), 1'b1, pk(4, 3, 2, 1));
        signed_mode = 1'b0;
        w_valid     = 1'b1;
        w_data      = w_2id[31:0];
        n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            check("drain_w_ready", 64'(w_ready), 64'd0);
            @(negedge clk);
            n++;
        end
        check("drain_exit", 64'(busy), 64'd0);
        check("drain_results_done", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
        check("reload_started", 64'(busy), 64'd1);
        load_w(1'b0, w_2id, 1);
        send_a(v4(1, 1, 1, 1), 1'b1, pk(2, 2, 2, 2));
        wait_idle();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_mxu.md
SYSTOLIC_MXU -- requirements
Module: systolic_mxu

Interface
REQ-001 SHALL have parameters: ROWS, default 4, array rows (activation lanes); COLS, default 4, array columns (result lanes); DATA_W, default 8, operand width; ACC_W, default 32, accumulator width; OUT_W, default 16, result width (OUT_W <= ACC_W).
REQ-002 SHALL have one clock, clk; reset is synchronous and active-high, port reset.
REQ-003 SHALL have ports, each as name, direction, width, meaning:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- signed_mode  in  1  operand signedness, sampled on first weight beat.
- w_valid / w_ready  in / out  1 / 1  weight-row handshake.
- w_data  in  COLS*DATA_W  one weight row per beat.
- a_valid / a_ready  in / out  1 / 1  activation handshake.
- a_data  in  ROWS*DATA_W  activation vector.
- a_last  in  1  final vector of batch.
- r_valid / r_ready  out / in  1 / 1  result handshake.
- r_data  out  COLS*OUT_W  result vector.
- busy  out  1  state != IDLE.

Function
REQ-004 SHALL be weight-stationary: ROWS x COLS PEs; activations flow east, partial sums flow south.
REQ-005 SHALL implement FSM IDLE -> LOAD_W -> IDLE, and IDLE -> COMPUTE -> DRAIN -> IDLE.
REQ-006 In IDLE, w_valid SHALL enter LOAD_W; w_valid has priority over a_valid when both are asserted.
REQ-007 In LOAD_W, w_ready=1; beat k (0..ROWS-1) loads row k; after beat ROWS-1 the row counter wraps to 0, weights_loaded is set, and the FSM returns to IDLE.
REQ-008 w_ready SHALL be 0 outside IDLE/LOAD_W; a weight reload while weights_loaded=1 overwrites all rows.
REQ-009 In IDLE with weights_loaded=1, an a_valid&&a_ready transfer SHALL enter COMPUTE, and that vector is accepted.
REQ-010 a_ready = (state IDLE or COMPUTE) && weights_loaded && !stall; stall = r_valid && !r_ready.
REQ-011 Input skew: lane i is delayed i cycles. Output deskew: column j is delayed COLS-1-j cycles.
REQ-012 r_data[j] SHALL equal sum over i of a[i]*W[i][j]. Products are 2*DATA_W bits, sign- or zero-extended per signed_mode to ACC_W, and accumulated modulo 2^ACC_W.
REQ-013 With no stall, the result SHALL be valid exactly ROWS+COLS cycles after acceptance; results are in order, one per accepted vector.
REQ-014 stall SHALL freeze all pipeline, skew, and deskew registers; r_data is held stable while r_valid && !r_ready; no results are lost or duplicated.
REQ-015 An accepted vector with a_last=1 SHALL move to DRAIN. In DRAIN, a_ready=0. DRAIN SHALL go to IDLE in the cycle after the last in-flight result is handshaken.
REQ-016 Bubbles (a_valid=0 in COMPUTE) SHALL propagate as invalid tokens and produce no r_valid.

Reset
REQ-017 reset SHALL clear the FSM to IDLE, all weights, partial sums, and valid tokens to 0, weights_loaded=0, and the row counter=0.
REQ-018 After reset: r_valid=0, r_data=0, a_ready=0, w_ready=1, busy=0.
REQ-019 Reset mid-LOAD_W/COMPUTE/DRAIN SHALL discard all in-flight data; no r_valid until new weights and vectors arrive.

Configuration
REQ-020 With MXU_SATURATE_EN defined, each ACC_W sum SHALL clamp to OUT_W range: unsigned [0, 2^OUT_W-1]; signed [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-021 Without MXU_SATURATE_EN, r_data SHALL be the low OUT_W bits of the sum (wrap).

Structure
REQ-022 Package mxu_pkg SHALL hold the FSM state enum (IDLE, LOAD_W, COMPUTE, DRAIN) and the default width constants.
REQ-023 Sub-module mxu_pe SHALL hold one weight register, the activation forward register, the MAC, and the partial-sum register, with enable and signed inputs.

Verification (ROWS=COLS=4, DATA_W=8, ACC_W=32, OUT_W=16)
REQ-024 Load identity weights, send a=[1,2,3,4] -> r_data=[1,2,3,4], r_valid 8 cycles after acceptance.
REQ-025 Unsigned, all weights 255, a all 255 -> sum 260100; SAT_EN r_data[j]=65535; without, 63492.
REQ-026 Signed, all weights -128, a all -128 -> sum 65536; SAT_EN r_data[j]=32767; without, 0.
REQ-027 Stream 3 vectors, r_ready=0 for 5 cycles at the first r_valid -> r_data held, a_ready=0, 3 results in order.
REQ-028 reset mid-COMPUTE with 2 vectors in flight -> next cycle r_valid=0, w_ready=1, a_ready=0; no stale results.
REQ-029 a_last on 2nd vector, w_valid held during DRAIN -> w_ready=0 until IDLE; 2 results, then reload accepted.
